// File: rtl/dmx_universe_tx.sv
// dmx_universe_tx: DMX512 universe transmitter clocked from the system clock.
// Emits BREAK / MAB / start code / data slots / MBB either continuously (enable)
// or once per trigger, reading channel bytes from an on-chip RAM.
// Optional feature macro: DMX_DOUBLE_BUFFER_EN selects a two-bank channel RAM
// with a commit-driven bank swap at frame boundaries.
`timescale 1ns/1ps

module dmx_universe_tx #(
    parameter int CLOCK_HZ   = 12000000,
    parameter int BAUD       = 250000,
    parameter int MAX_SLOTS  = 512,
    parameter int BREAK_BITS = 23,
    parameter int MAB_BITS   = 3,
    parameter int MBB_BITS   = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       trigger,
    input  logic [9:0] slot_count,
    input  logic [7:0] start_code,
    input  logic       wr_en,
    input  logic [8:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       commit,
    output logic       signal,
    output logic       signal_n,
    output logic       busy,
    output logic       frame_done
);

    // Clocks per bit time, rounded to nearest.
    localparam int DIV   = (CLOCK_HZ + BAUD / 2) / BAUD;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW    = (MAX_SLOTS > 1) ? $clog2(MAX_SLOTS) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(DIV - 1);
    localparam logic [15:0]      BREAK_LAST = 16'(BREAK_BITS - 1);
    localparam logic [15:0]      MAB_LAST   = 16'(MAB_BITS - 1);
    localparam logic [15:0]      MBB_LAST   = 16'(MBB_BITS - 1);
    localparam logic [9:0]       SLOTS_MAX  = 10'(MAX_SLOTS);

    typedef enum logic [2:0] {
        IDLE,
        BREAK,
        MAB,
        SLOT,
        MBB
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [15:0]      bit_q, bit_d;       // bit times elapsed in the current state
    logic [9:0]       slot_q, slot_d;     // slot index, 0 = start code
    logic [7:0]       shift_q, shift_d;   // byte being serialised, LSB first
    logic [9:0]       slots_q;            // clamped data-slot count for this frame
    logic [7:0]       start_code_q;
    logic             signal_q, signal_d;
    logic             busy_q, busy_d;
    logic             frame_done_q, frame_done_d;

    logic             tick;
    logic             start_frame;
    logic             end_frame;
    logic             rd_en;
    logic [AW-1:0]    rd_addr;
    logic [7:0]       rd_data_q;
    logic             wr_ok;
    logic [9:0]       slots_clamped;

    assign tick    = (div_q == DIV_LAST);
    assign rd_addr = slot_q[AW-1:0];
    assign wr_ok   = wr_en && (32'(wr_addr) < 32'(MAX_SLOTS));

    assign slots_clamped = (slot_count == 10'd0)      ? 10'd1 :
                           (slot_count > SLOTS_MAX)   ? SLOTS_MAX :
                                                        slot_count;

    // Next-state, counters, fetch strobe and line level for the frame sequencer.
    // NOTE: every output of this block gets a default first, so no path leaves a value held and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        div_d        = tick ? '0 : div_q + 1'b1;
        bit_d        = bit_q;
        slot_d       = slot_q;
        shift_d      = shift_q;
        frame_done_d = 1'b0;
        start_frame  = 1'b0;
        end_frame    = 1'b0;
        rd_en        = 1'b0;

        case (state_q)
            IDLE: begin
                div_d = '0;
                bit_d = '0;
                if (enable || trigger) begin
                    state_d     = BREAK;
                    start_frame = 1'b1;
                end
            end
            BREAK: begin
                if (tick) begin
                    if (bit_q == BREAK_LAST) begin
                        state_d = MAB;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 16'd1;
                    end
                end
            end
            MAB: begin
                if (tick) begin
                    if (bit_q == MAB_LAST) begin
                        state_d = SLOT;
                        bit_d   = '0;
                        slot_d  = '0;
                        shift_d = start_code_q;
                    end else begin
                        bit_d = bit_q + 16'd1;
                    end
                end
            end
            SLOT: begin
                if (tick) begin
                    // Fetch the following slot's byte as the first stop bit begins,
                    // two bit times ahead of its start bit.
                    if (bit_q == 16'd8 && slot_q < slots_q) begin
                        rd_en = 1'b1;
                    end
                    if (bit_q == 16'd10) begin
                        bit_d = '0;
                        if (slot_q == slots_q) begin
                            if (MBB_BITS == 0) begin
                                end_frame = 1'b1;
                            end else begin
                                state_d = MBB;
                            end
                        end else begin
                            slot_d  = slot_q + 10'd1;
                            shift_d = rd_data_q;
                        end
                    end else begin
                        bit_d = bit_q + 16'd1;
                        if (bit_q >= 16'd1 && bit_q <= 16'd8) begin
                            shift_d = shift_q >> 1;
                        end
                    end
                end
            end
            MBB: begin
                if (tick) begin
                    if (bit_q == MBB_LAST) begin
                        end_frame = 1'b1;
                    end else begin
                        bit_d = bit_q + 16'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A zero-length MBB folds the frame end into the last stop bit's edge.
        if (end_frame) begin
            frame_done_d = 1'b1;
            bit_d        = '0;
            div_d        = '0;
            if (enable) begin
                state_d     = BREAK;
                start_frame = 1'b1;
            end else begin
                state_d = IDLE;
            end
        end

        busy_d = (state_d != IDLE);

        case (state_d)
            BREAK:   signal_d = 1'b0;
            SLOT: begin
                if (bit_d == 16'd0) begin
                    signal_d = 1'b0;
                end else if (bit_d <= 16'd8) begin
                    signal_d = shift_d[0];
                end else begin
                    signal_d = 1'b1;
                end
            end
            default: signal_d = 1'b1;
        endcase
    end

    // Control registers; a synchronous reset drops the line to idle immediately.
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            div_q        <= '0;
            bit_q        <= '0;
            slot_q       <= '0;
            signal_q     <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            bit_q        <= bit_d;
            slot_q       <= slot_d;
            signal_q     <= signal_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Datapath registers: frame parameters latched at BREAK entry, serialiser byte.
    always_ff @(posedge clock) begin
        shift_q <= shift_d;
        if (start_frame) begin
            slots_q      <= slots_clamped;
            start_code_q <= start_code;
        end
    end

`ifdef DMX_DOUBLE_BUFFER_EN
    logic [7:0] mem_q [0:1][0:MAX_SLOTS-1];
    logic       front_q;
    logic       pending_q;
    logic       swap;

    // Banks swap only while idle or on BREAK entry, so a frame never mixes banks.
    assign swap = (commit || pending_q) && (state_q == IDLE || start_frame);

    // Front-bank selector and pending commit flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            front_q   <= 1'b0;
            pending_q <= 1'b0;
        end else if (swap) begin
            front_q   <= ~front_q;
            pending_q <= 1'b0;
        end else if (commit) begin
            pending_q <= 1'b1;
        end
    end

    // Host writes the back bank; the transmitter reads the front bank.
    // NOTE: channel RAM has no reset; its contents are host-owned and a reset loop would prevent RAM inference.
    always_ff @(posedge clock) begin
        if (wr_ok) begin
            mem_q[~front_q][wr_addr[AW-1:0]] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[front_q][rd_addr];
        end
    end
`else
    logic [7:0] mem_q [0:MAX_SLOTS-1];
    logic       unused_commit;

    assign unused_commit = commit;

    // Single-bank channel RAM; a same-address write and fetch returns the old byte.
    // NOTE: channel RAM has no reset; its contents are host-owned and a reset loop would prevent RAM inference.
    always_ff @(posedge clock) begin
        if (wr_ok) begin
            mem_q[wr_addr[AW-1:0]] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end
`endif

    assign signal     = signal_q;
    assign signal_n   = ~signal_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_dmx_universe_tx.sv
// tb_dmx_universe_tx: scoreboard bench for dmx_universe_tx.
// The DUT runs at the default 12 MHz / 250 kbaud (48 clocks per bit) with a
// 32-entry channel RAM so that clamped frames stay short.
`timescale 1ns/1ps

module tb_dmx_universe_tx;

    localparam int DIV        = 48;
    localparam int MAX_SLOTS  = 32;
    localparam int BREAK_CLKS = 23 * DIV;
    localparam int MAB_CLKS   = 3 * DIV;
    localparam int SLOT_CLKS  = 11 * DIV;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic       trigger;
    logic [9:0] slot_count;
    logic [7:0] start_code;
    logic       wr_en;
    logic [8:0] wr_addr;
    logic [7:0] wr_data;
    logic       commit;
    logic       signal;
    logic       signal_n;
    logic       busy;
    logic       frame_done;

    int         n_tests = 0;
    int         n_fail  = 0;

    logic [7:0] tb_ram [0:MAX_SLOTS-1];
    logic [7:0] exp_q [$];
    int         exp_len_q [$];

    always #5 clock = ~clock;

    dmx_universe_tx #(
        .CLOCK_HZ  (12000000),
        .BAUD      (250000),
        .MAX_SLOTS (MAX_SLOTS),
        .BREAK_BITS(23),
        .MAB_BITS  (3),
        .MBB_BITS  (0)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .trigger   (trigger),
        .slot_count(slot_count),
        .start_code(start_code),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .commit    (commit),
        .signal    (signal),
        .signal_n  (signal_n),
        .busy      (busy),
        .frame_done(frame_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic ram_write(input int addr, input logic [7:0] data);
        wr_en   = 1'b1;
        wr_addr = 9'(addr);
        wr_data = data;
        @(negedge clock);
        wr_en   = 1'b0;
    endtask

    // Idle-time load; with two banks the byte is written to both so either bank is current.
    task automatic load(input int addr, input logic [7:0] data);
        ram_write(addr, data);
`ifdef DMX_DOUBLE_BUFFER_EN
        commit = 1'b1;
        @(negedge clock);
        commit = 1'b0;
        ram_write(addr, data);
`endif
        tb_ram[addr] = data;
    endtask

    task automatic pulse_trigger();
        trigger = 1'b1;
        @(negedge clock);
        trigger = 1'b0;
    endtask

    // Push one frame's expected slot bytes: start code then RAM[0..n-1].
    task automatic expect_frame(input logic [7:0] sc, input int n);
        exp_len_q.push_back(n + 1);
        exp_q.push_back(sc);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(tb_ram[k]);
        end
    endtask

    // Decode one frame from the line and compare against the scoreboard.
    // cont=1: the next BREAK must start right after the last stop bit.
    task automatic capture_frame(input bit cont);
        int          n;
        int          lo;
        int          hi;
        int          len;
        logic [10:0] bits;
        logic [7:0]  e;
        n = 0;
        while (signal !== 1'b0 && n < 4000) begin
            @(negedge clock);
            n++;
        end
        if (signal !== 1'b0) begin
            check("break_start", {31'd0, signal}, 32'd0);
            return;
        end
        check("busy_in_frame", {31'd0, busy}, 32'd1);
        check("signal_n_break", {31'd0, signal_n}, 32'd1);
        lo = 0;
        while (signal === 1'b0 && lo < 4000) begin
            @(negedge clock);
            lo++;
        end
        check("break_len", lo, BREAK_CLKS);
        hi = 0;
        while (signal === 1'b1 && hi < 4000) begin
            @(negedge clock);
            hi++;
        end
        check("mab_len", hi, MAB_CLKS);
        len = (exp_len_q.size() > 0) ? exp_len_q.pop_front() : 0;
        for (int j = 0; j < len; j++) begin
            for (int b = 0; b < 11; b++) begin
                repeat (DIV / 2) @(negedge clock);
                bits[b] = signal;
                repeat (DIV - DIV / 2) @(negedge clock);
            end
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            check($sformatf("slot%0d_framing", j), {29'd0, bits[0], bits[10:9]}, 32'h3);
            check($sformatf("slot%0d_data", j), {24'd0, bits[8:1]}, {24'd0, e});
        end
        check("frame_done", {31'd0, frame_done}, 32'd1);
        if (cont) begin
            check("next_break", {31'd0, signal}, 32'd0);
            check("busy_held", {31'd0, busy}, 32'd1);
        end else begin
            check("idle_signal", {31'd0, signal}, 32'd1);
            check("busy_clear", {31'd0, busy}, 32'd0);
            @(negedge clock);
            check("frame_done_once", {31'd0, frame_done}, 32'd0);
        end
    endtask

    // Line must stay idle and not busy for n clocks.
    task automatic idle_quiet(input string tag, input int n);
        int bad;
        bad = 0;
        repeat (n) begin
            @(negedge clock);
            if (signal !== 1'b1 || busy !== 1'b0) bad++;
        end
        check(tag, bad, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        enable     = 1'b0;
        trigger    = 1'b0;
        slot_count = 10'd0;
        start_code = 8'h00;
        wr_en      = 1'b0;
        wr_addr    = 9'd0;
        wr_data    = 8'h00;
        commit     = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_signal", {31'd0, signal}, 32'd1);
        check("rst_signal_n", {31'd0, signal_n}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_frame_done", {31'd0, frame_done}, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Single triggered frame, 1 data slot; a second trigger while busy is ignored.
        load(0, 8'hFF);
        slot_count = 10'd1;
        start_code = 8'h00;
        expect_frame(8'h00, 1);
        pulse_trigger();
        fork
            capture_frame(1'b0);
            begin
                repeat (600) @(negedge clock);
                pulse_trigger();
            end
        join
        idle_quiet("no_retrigger", 300);

        // Continuous mode, back-to-back frames; enable drops mid-slot in frame 2.
        load(0, 8'hA5);
        load(1, 8'h01);
        load(2, 8'h80);
        slot_count = 10'd3;
        expect_frame(8'h00, 3);
        expect_frame(8'h00, 3);
        enable = 1'b1;
        @(negedge clock);
        capture_frame(1'b1);
        fork
            capture_frame(1'b0);
            begin
                repeat (2000) @(negedge clock);
                enable = 1'b0;
            end
        join
        idle_quiet("idle_after_enable", 300);

        // slot_count = 0 sends exactly one data slot.
        slot_count = 10'd0;
        start_code = 8'hCC;
        expect_frame(8'hCC, 1);
        pulse_trigger();
        capture_frame(1'b0);

        // slot_count above MAX_SLOTS clamps to MAX_SLOTS data slots.
        for (int k = 0; k < MAX_SLOTS; k++) begin
            load(k, 8'((k * 37 + 5) & 8'hFF));
        end
        slot_count = 10'd600;
        start_code = 8'h3C;
        expect_frame(8'h3C, MAX_SLOTS);
        pulse_trigger();
        capture_frame(1'b0);

        // Reset during slot 2 data bits, then a fresh full-length frame.
        slot_count = 10'd3;
        start_code = 8'h96;
        pulse_trigger();
        repeat (BREAK_CLKS + MAB_CLKS + 2 * SLOT_CLKS + DIV + 100) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("midrst_signal", {31'd0, signal}, 32'd1);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_frame_done", {31'd0, frame_done}, 32'd0);
        reset = 1'b0;
        idle_quiet("idle_after_reset", 50);
        expect_frame(8'h96, 3);
        pulse_trigger();
        capture_frame(1'b0);

        // Write to addr 0 after its fetch: old value now, new value next frame.
        load(0, 8'h11);
        load(1, 8'h22);
        load(2, 8'h33);
        start_code = 8'h00;
        expect_frame(8'h00, 3);
        enable = 1'b1;
        @(negedge clock);
        fork
            capture_frame(1'b1);
            begin
                repeat (BREAK_CLKS + MAB_CLKS + 2 * SLOT_CLKS + 10) @(negedge clock);
                ram_write(0, 8'h55);
                commit = 1'b1;
                @(negedge clock);
                commit = 1'b0;
            end
        join
        tb_ram[0] = 8'h55;
        expect_frame(8'h00, 3);
        fork
            capture_frame(1'b0);
            begin
                repeat (1500) @(negedge clock);
                enable = 1'b0;
            end
        join
        idle_quiet("idle_end", 100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
